// File: rtl/problema1_pio_pkg.sv
// Shared constants for the problema1 edge-capturing input PIO.
// Register addresses, edge-type and irq-type selectors.
package problema1_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;
  localparam logic [1:0] ADDR_RSVD    = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/problema1_pio_sync.sv
// WIDTH x STAGES flop synchronizer with async active-low clear.
// Ports: clk, reset_n, d (async in), q (synchronized out); STAGES=0 passes d.
module problema1_pio_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (STAGES == 0) begin : g_pass
    logic clk_unused;
    assign clk_unused = clk ^ reset_n;
    assign q = d;
  end else begin : g_chain
    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < STAGES; i++)
          chain[i] <= '0;
      end else begin
        chain[0] <= d;
        for (int i = 1; i < STAGES; i++)
          chain[i] <= chain[i-1];
      end
    end

    assign q = chain[STAGES-1];
  end

endmodule

// File: rtl/problema1_pio_in_edge.sv
// Avalon-MM input PIO: synchronized data, irqmask, edgecapture, irq.
// Ports: clk, reset_n, address/chipselect/write_n/writedata, in_port, readdata, irq.
module problema1_pio_in_edge
  import problema1_pio_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING,
  parameter int IRQ_TYPE    = IRQ_EDGE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

  logic [DATA_WIDTH-1:0] sync_q;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] edge_det;
  logic [DATA_WIDTH-1:0] irqmask;
  logic [DATA_WIDTH-1:0] edgecap;
  logic [DATA_WIDTH-1:0] ec_set;
  logic [DATA_WIDTH-1:0] ec_clr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [2:0]            arm_cnt;
  logic                  armed;
  logic                  wr_en;
  logic [31:0]           rd_mux;

  problema1_pio_sync #(
    .WIDTH  (DATA_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (in_port),
    .q       (sync_q)
  );

  if (DATA_WIDTH < 32) begin : g_wd
    logic wd_unused;
    assign wd_unused = ^writedata[31:DATA_WIDTH];
  end

  assign wdata = writedata[DATA_WIDTH-1:0];
  assign wr_en = chipselect & ~write_n;
  assign armed = (arm_cnt == ARM_MAX);

  if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
    assign edge_det = ~sync_q & prev_q;
  end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
    assign edge_det = sync_q ^ prev_q;
  end else begin : g_rise
    assign edge_det = sync_q & ~prev_q;
  end

  // Set is OR-ed after the clear so a same-cycle edge is never lost.
  assign ec_set = armed ? edge_det : '0;
  assign ec_clr = (wr_en && address == ADDR_EDGECAP) ? wdata : '0;

  always_comb begin
    rd_mux = '0;
    unique case (address)
      ADDR_DATA:    rd_mux = 32'(sync_q);
      ADDR_IRQMASK: rd_mux = 32'(irqmask);
      ADDR_EDGECAP: rd_mux = 32'(edgecap);
      default:      rd_mux = '0;
    endcase
  end

  // Hold off capture until the chain and prev_q hold real input data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      arm_cnt <= '0;
    else if (!armed)
      arm_cnt <= arm_cnt + 3'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q   <= '0;
      irqmask  <= '0;
      edgecap  <= '0;
      readdata <= '0;
    end else begin
      prev_q   <= sync_q;
      edgecap  <= (edgecap & ~ec_clr) | ec_set;
      readdata <= rd_mux;
      if (wr_en && address == ADDR_IRQMASK)
        irqmask <= wdata;
    end
  end

  if (IRQ_TYPE == IRQ_LEVEL) begin : g_lvl
    assign irq = |(sync_q & irqmask);
  end else begin : g_edg
    assign irq = |(edgecap & irqmask);
  end

endmodule
